// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic matrix-multiply engine.
// Result reduction saturates when SYSTOLIC_SAT_EN is defined, otherwise wraps.
package systolic_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_e;

    localparam int RED_W = 64;

    function automatic int beat_cnt_w(input int k_max);
        return (k_max < 1) ? 1 : $clog2(k_max + 1);
    endfunction

    // Must hold ROWS+COLS-2 (drain length) without overflow.
    function automatic int drain_cnt_w(input int rows, input int cols);
        return (rows + cols < 2) ? 1 : $clog2(rows + cols);
    endfunction

    // Reduces an accumulator to out_w bits; the caller keeps the low out_w bits.
    function automatic logic signed [RED_W-1:0] reduce_acc(
        input logic signed [RED_W-1:0] acc,
        input int                      out_w
    );
`ifdef SYSTOLIC_SAT_EN
        logic signed [RED_W-1:0] hi;
        logic signed [RED_W-1:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (acc > hi) begin
            return hi;
        end else if (acc < lo) begin
            return lo;
        end else begin
            return acc;
        end
`else
        return (acc <<< (RED_W - out_w)) >>> (RED_W - out_w);
`endif
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One output-stationary processing element: forwards a right and b down,
// accumulates a*b every cycle and keeps a registered, reduced copy of the sum.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic signed [DATA_W-1:0] b_in,
    output logic signed [DATA_W-1:0] a_out,
    output logic signed [DATA_W-1:0] b_out,
    output logic        [OUT_W-1:0]  res
);

    logic signed [DATA_W-1:0]   a_r;
    logic signed [DATA_W-1:0]   b_r;
    logic signed [ACC_W-1:0]    acc_r;
    logic        [OUT_W-1:0]    res_r;
    logic signed [2*DATA_W-1:0] prod_s;
    logic signed [ACC_W-1:0]    acc_nxt_s;

    assign prod_s    = a_in * b_in;
    assign acc_nxt_s = acc_r + ACC_W'(prod_s);

    // Operand forwarding, accumulation and result register; res tracks acc.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            a_r   <= {DATA_W{1'b0}};
            b_r   <= {DATA_W{1'b0}};
            acc_r <= {ACC_W{1'b0}};
            res_r <= {OUT_W{1'b0}};
        end else begin
            a_r   <= a_in;
            b_r   <= b_in;
            acc_r <= acc_nxt_s;
            res_r <= OUT_W'(reduce_acc(RED_W'(acc_nxt_s), OUT_W));
        end
    end

    assign a_out = a_r;
    assign b_out = b_r;
    assign res   = res_r;

endmodule

// File: rtl/systolic_mm_engine.sv
// Output-stationary ROWSxCOLS systolic matrix multiply with internal skew and
// handshake controller. Define SYSTOLIC_SAT_EN for saturating results.
module systolic_mm_engine
    import systolic_pkg::*;
#(
    parameter int ROWS   = 16,
    parameter int COLS   = 16,
    parameter int K_MAX  = 16,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [beat_cnt_w(K_MAX)-1:0]   k_len,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ROWS*DATA_W-1:0]         in_a,
    input  logic [COLS*DATA_W-1:0]         in_b,
    output logic                           busy,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ROWS*COLS*OUT_W-1:0]     out_c,
    output logic                           done
);

    localparam int KW        = beat_cnt_w(K_MAX);
    localparam int DW        = drain_cnt_w(ROWS, COLS);
    localparam int DRAIN_LEN = ROWS + COLS - 2;
    localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_LEN > 0) ? DRAIN_LEN - 1 : 0);
    localparam state_e AFTER_LOAD = (DRAIN_LEN == 0) ? S_OUT : S_DRAIN;

    if (ACC_W < 2 * DATA_W + $clog2(K_MAX)) begin : g_acc_w_check
        $error("systolic_mm_engine: ACC_W too narrow for DATA_W and K_MAX");
    end

    state_e           state_r;
    state_e           state_nxt_s;
    logic             clr_s;
    logic             beat_s;
    logic [KW-1:0]    k_lat_r;
    logic [KW-1:0]    k_clamp_s;
    logic [KW-1:0]    beat_cnt_r;
    logic [DW-1:0]    drain_cnt_r;
    logic             in_ready_r;
    logic             busy_r;
    logic             out_valid_r;

    assign beat_s    = (state_r == S_LOAD) && in_valid;
    assign k_clamp_s = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;

    // Next-state decode; clr_s wipes the array when a job is accepted.
    always_comb begin
        state_nxt_s = state_r;
        clr_s       = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    clr_s = 1'b1;
                    if (k_len == {KW{1'b0}}) begin
                        state_nxt_s = AFTER_LOAD;
                    end else begin
                        state_nxt_s = S_LOAD;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (beat_s && ((beat_cnt_r + KW'(1)) == k_lat_r)) begin
                    state_nxt_s = AFTER_LOAD;
                end else begin
                    state_nxt_s = S_LOAD;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST) begin
                    state_nxt_s = S_OUT;
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_OUT;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            k_lat_r     <= {KW{1'b0}};
            beat_cnt_r  <= {KW{1'b0}};
            drain_cnt_r <= {DW{1'b0}};
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == S_LOAD);
            busy_r      <= (state_nxt_s != S_IDLE);
            out_valid_r <= (state_nxt_s == S_OUT);
            if (clr_s) begin
                k_lat_r    <= k_clamp_s;
                beat_cnt_r <= {KW{1'b0}};
            end else if (beat_s) begin
                beat_cnt_r <= beat_cnt_r + KW'(1);
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end
            if (state_r == S_DRAIN) begin
                drain_cnt_r <= drain_cnt_r + DW'(1);
            end else begin
                drain_cnt_r <= {DW{1'b0}};
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign done      = out_valid_r && out_ready;

    // Bubbles and non-LOAD cycles feed zeros, which leave every sum untouched.
    logic signed [DATA_W-1:0] a_inj_s  [ROWS];
    logic signed [DATA_W-1:0] b_inj_s  [COLS];
    logic signed [DATA_W-1:0] a_edge_s [ROWS];
    logic signed [DATA_W-1:0] b_edge_s [COLS];

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_a_skew
        assign a_inj_s[gi] = beat_s ? in_a[gi*DATA_W +: DATA_W] : {DATA_W{1'b0}};
        if (gi == 0) begin : g_direct
            assign a_edge_s[gi] = a_inj_s[gi];
        end else begin : g_dly
            logic signed [DATA_W-1:0] dly_r [gi];
            // Row gi of A is delayed gi cycles.
            always_ff @(posedge clk) begin
                if (reset || clr_s) begin
                    for (int d = 0; d < gi; d++) dly_r[d] <= {DATA_W{1'b0}};
                end else begin
                    dly_r[0] <= a_inj_s[gi];
                    for (int d = 1; d < gi; d++) dly_r[d] <= dly_r[d-1];
                end
            end
            assign a_edge_s[gi] = dly_r[gi-1];
        end
    end

    for (genvar gj = 0; gj < COLS; gj++) begin : g_b_skew
        assign b_inj_s[gj] = beat_s ? in_b[gj*DATA_W +: DATA_W] : {DATA_W{1'b0}};
        if (gj == 0) begin : g_direct
            assign b_edge_s[gj] = b_inj_s[gj];
        end else begin : g_dly
            logic signed [DATA_W-1:0] dly_r [gj];
            // Column gj of B is delayed gj cycles.
            always_ff @(posedge clk) begin
                if (reset || clr_s) begin
                    for (int d = 0; d < gj; d++) dly_r[d] <= {DATA_W{1'b0}};
                end else begin
                    dly_r[0] <= b_inj_s[gj];
                    for (int d = 1; d < gj; d++) dly_r[d] <= dly_r[d-1];
                end
            end
            assign b_edge_s[gj] = dly_r[gj-1];
        end
    end

    logic signed [DATA_W-1:0] pe_a_s [ROWS][COLS];
    logic signed [DATA_W-1:0] pe_b_s [ROWS][COLS];

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < COLS; gj++) begin : g_col
            logic signed [DATA_W-1:0] a_w_s;
            logic signed [DATA_W-1:0] b_w_s;
            if (gj == 0) begin : g_a_edge
                assign a_w_s = a_edge_s[gi];
            end else begin : g_a_fwd
                assign a_w_s = pe_a_s[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign b_w_s = b_edge_s[gj];
            end else begin : g_b_fwd
                assign b_w_s = pe_b_s[gi-1][gj];
            end
            systolic_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W),
                .OUT_W  (OUT_W)
            ) u_pe (
                .clk   (clk),
                .reset (reset),
                .clr   (clr_s),
                .a_in  (a_w_s),
                .b_in  (b_w_s),
                .a_out (pe_a_s[gi][gj]),
                .b_out (pe_b_s[gi][gj]),
                .res   (out_c[(gi*COLS+gj)*OUT_W +: OUT_W])
            );
        end
    end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Self-checking bench for systolic_mm_engine: directed and random jobs checked
// against a plain-arithmetic matrix product model.
module tb_systolic_mm_engine;

    localparam int ROWS   = 16;
    localparam int COLS   = 16;
    localparam int K_MAX  = 16;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 24;
    localparam int OUT_W  = 8;
    localparam int KW     = $clog2(K_MAX + 1);
    localparam int LAT    = ROWS + COLS - 2;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       start;
    logic [KW-1:0]              k_len;
    logic                       in_valid;
    logic                       in_ready;
    logic [ROWS*DATA_W-1:0]     in_a;
    logic [COLS*DATA_W-1:0]     in_b;
    logic                       busy;
    logic                       out_valid;
    logic                       out_ready;
    logic [ROWS*COLS*OUT_W-1:0] out_c;
    logic                       done;

    int a_m   [ROWS][K_MAX];
    int b_m   [K_MAX][COLS];
    int exp_c [ROWS][COLS];
    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    systolic_mm_engine #(
        .ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX),
        .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c), .done(done)
    );

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_reduce(input longint acc);
        longint lim;
        longint w;
        lim = longint'(1) << (OUT_W - 1);
        w   = acc;
`ifdef SYSTOLIC_SAT_EN
        if (w > lim - 1) w = lim - 1;
        else if (w < -lim) w = -lim;
`else
        w = w % (2 * lim);
        if (w < 0) w = w + 2 * lim;
        if (w >= lim) w = w - 2 * lim;
`endif
        return int'(w);
    endfunction

    task automatic compute_ref(input int keff);
        longint s;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                s = 0;
                for (int k = 0; k < keff; k++) s += longint'(a_m[i][k]) * longint'(b_m[k][j]);
                exp_c[i][j] = ref_reduce(s);
            end
    endtask

    task automatic fill_identity();
        for (int k = 0; k < K_MAX; k++) begin
            for (int i = 0; i < ROWS; i++) a_m[i][k] = (i == k) ? 1 : 0;
            for (int j = 0; j < COLS; j++) b_m[k][j] = k + j;
        end
    endtask

    task automatic fill_const(input int av, input int bv);
        for (int k = 0; k < K_MAX; k++) begin
            for (int i = 0; i < ROWS; i++) a_m[i][k] = av;
            for (int j = 0; j < COLS; j++) b_m[k][j] = bv;
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < K_MAX; k++) begin
            for (int i = 0; i < ROWS; i++) a_m[i][k] = int'($urandom_range(0, 255)) - 128;
            for (int j = 0; j < COLS; j++) b_m[k][j] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    task automatic check_reset_state(input string name);
        check_val({name, " in_ready"}, 64'(in_ready), 64'd0);
        check_val({name, " busy"}, 64'(busy), 64'd0);
        check_val({name, " out_valid"}, 64'(out_valid), 64'd0);
        check_val({name, " done"}, 64'(done), 64'd0);
        check_val({name, " out_c_zero"}, 64'(out_c == '0), 64'd1);
    endtask

    task automatic start_job(input int klen);
        @(negedge clk);
        start = 1'b1;
        k_len = KW'(klen);
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: contiguous beats, 1: alternate valid/idle, 2: random gaps
    task automatic feed(input string name, input int nbeats, input int mode);
        int  idx;
        int  guard;
        bit  v;
        idx   = 0;
        guard = 0;
        while (idx < nbeats && guard < 500) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? ((guard % 2) == 0) : 1'($urandom_range(0, 1));
            if (v) check_val({name, " in_ready_beat"}, 64'(in_ready), 64'd1);
            for (int i = 0; i < ROWS; i++)
                in_a[i*DATA_W +: DATA_W] = v ? DATA_W'(a_m[i][idx]) : DATA_W'($urandom);
            for (int j = 0; j < COLS; j++)
                in_b[j*DATA_W +: DATA_W] = v ? DATA_W'(b_m[idx][j]) : DATA_W'($urandom);
            in_valid = v;
            @(negedge clk);
            if (v) idx++;
            guard++;
        end
        in_valid = 1'b0;
        if (guard >= 500) check_val({name, " feed_timeout"}, 64'(guard), 64'(nbeats));
    endtask

    // Called at the falling edge right after the last beat (or start) edge.
    task automatic wait_out(input string name, input bit junk);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            if (junk) begin
                in_valid = 1'($urandom_range(0, 1));
                in_a = {ROWS{DATA_W'($urandom)}};
                in_b = {COLS{DATA_W'($urandom)}};
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check_val({name, " latency"}, 64'(n), 64'(LAT));
    endtask

    task automatic check_result(input string name);
        logic [OUT_W-1:0] g;
        logic [OUT_W-1:0] e;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                g = out_c[(i*COLS+j)*OUT_W +: OUT_W];
                e = OUT_W'(exp_c[i][j]);
                check_val($sformatf("%s c[%0d][%0d]", name, i, j), 64'(g), 64'(e));
            end
    endtask

    task automatic finish_job(input string name, input int hold, input bit start_in_win, input bit start_on_hs);
        int d0;
        logic [ROWS*COLS*OUT_W-1:0] snap;
        d0   = done_cnt;
        snap = out_c;
        for (int c = 0; c < hold; c++) begin
            out_ready = 1'b0;
            start     = start_in_win && (c == 3);
            @(negedge clk);
            check_val({name, " hold_valid"}, 64'(out_valid), 64'd1);
            check_val({name, " hold_stable"}, 64'(out_c == snap), 64'd1);
            check_val({name, " hold_done"}, 64'(done), 64'd0);
        end
        start     = start_on_hs;
        out_ready = 1'b1;
        #1;
        check_val({name, " done_on_hs"}, 64'(done), 64'd1);
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check_val({name, " idle_out_valid"}, 64'(out_valid), 64'd0);
        check_val({name, " idle_busy"}, 64'(busy), 64'd0);
        check_val({name, " done_count"}, 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic do_job(input string name, input int klen, input int mode, input bit junk,
                          input int hold, input bit start_in_win, input bit start_on_hs);
        int keff;
        keff = (klen > K_MAX) ? K_MAX : klen;
        compute_ref(keff);
        start_job(klen);
        check_val({name, " busy"}, 64'(busy), 64'd1);
        check_val({name, " in_ready"}, 64'(in_ready), 64'(keff > 0));
        if (keff > 0) feed(name, keff, mode);
        wait_out(name, junk);
        check_result(name);
        finish_job(name, hold, start_in_win, start_on_hs);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        k_len     = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;

        fill_identity();
        do_job("identity", 16, 0, 1'b0, 0, 1'b0, 1'b0);
        do_job("bubbles", 16, 1, 1'b0, 0, 1'b0, 1'b0);

        fill_const(127, 127);
        do_job("overflow", 16, 2, 1'b1, 0, 1'b0, 1'b0);

        fill_const(-3, 5);
        do_job("signed", 1, 0, 1'b0, 0, 1'b0, 1'b0);

        fill_identity();
        do_job("backpressure", 16, 0, 1'b1, 10, 1'b1, 1'b1);

        // Reset in the middle of a load, then a clean identity job.
        start_job(16);
        feed("partial", 5, 0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("mid_reset");
        reset = 1'b0;
        do_job("after_reset", 16, 0, 1'b0, 0, 1'b0, 1'b0);

        fill_random();
        do_job("k_zero", 0, 0, 1'b1, 1, 1'b0, 1'b0);
        do_job("k_clamp", K_MAX + 3, 2, 1'b0, 0, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            fill_random();
            do_job($sformatf("rand%0d", r), int'($urandom_range(0, K_MAX + 3)), 2, 1'b1,
                   int'($urandom_range(0, 3)), 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/systolic_mm_engine.md
# systolic_mm_engine

Parametrised output-stationary systolic matrix-multiply engine with an integrated controller. It computes C = A·B for a ROWS×K by K×COLS product, with K chosen at run time up to K_MAX. Input skewing is internal, both input and output use valid/ready handshakes, and completion is decided exactly by a cycle counter. It is the next-generation matrix-multiply block of the ECG classifier datapath, fed by the operand buffers and drained by the activation stage.

## Interface
- ROWS, 16: rows of A and C; PE rows.
- COLS, 16: columns of B and C; PE columns.
- K_MAX, 16: maximum inner dimension.
- DATA_W, 8: signed two's-complement operand width.
- ACC_W, 24: signed accumulator width. Must be ≥ 2·DATA_W + $clog2(K_MAX); violation is an elaboration error.
- OUT_W, 8: signed result width.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begins a job; honoured only in IDLE.
- k_len  in  $clog2(K_MAX+1)  inner dimension, sampled on accepted start; values > K_MAX are clamped to K_MAX.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  engine accepts a beat.
- in_a  in  ROWS·DATA_W  beat k carries column k of A (row i at bits [i·DATA_W +: DATA_W]).
- in_b  in  COLS·DATA_W  beat k carries row k of B (column j at bits [j·DATA_W +: DATA_W]).
- busy  out  1  high in any state other than IDLE.
- out_valid  out  1  result matrix valid.
- out_ready  in  1  consumer accepts the result.
- out_c  out  ROWS·COLS·OUT_W  C(i,j) at index i·COLS+j.
- done  out  1  one-cycle pulse on the output handshake.

## Operation
- FSM states: S_IDLE → S_LOAD → S_DRAIN → S_OUT → S_IDLE.
- S_IDLE
  - in_ready=0.
  - start=1: latch k_len, clear all accumulators and skew registers, go to S_LOAD. If k_len==0, go directly to S_DRAIN instead.
- S_LOAD
  - in_ready=1.
  - Each in_valid&&in_ready beat increments the beat count.
  - The array advances every cycle. A cycle without a beat injects zeros (bubble), which does not change any result.
  - After the k_len-th accepted beat, go to S_DRAIN.
- S_DRAIN
  - in_ready=0. Zeros are injected.
  - Lasts exactly ROWS+COLS-2 cycles (drain counter), then go to S_OUT.
- S_OUT
  - out_valid=1. out_c is stable while out_valid&&!out_ready.
  - On handshake: done=1 for that cycle, then go to S_IDLE.
- Skew
  - Row i of A is delayed i cycles before PE(i,0).
  - Column j of B is delayed j cycles before PE(0,j).
- PE(i,j), each cycle:
  - acc += a·b, computed as a signed ACC_W-bit sum.
  - a is forwarded right; b is forwarded down.
  - The operand pair from beat k accumulates i+j cycles after the edge at which beat k was accepted.
- Result: out_c(i,j) is acc(i,j) reduced to OUT_W bits (see Configuration).
- Boundary conditions:
  - start outside S_IDLE is ignored, including start in the same cycle as the output handshake.
  - in_valid outside S_LOAD is ignored.
  - reset in any state: state → S_IDLE on the next edge; all accumulators, counters and outputs are cleared. No residue carries into the next job.

## Timing
- Reset values: in_ready=0, busy=0, out_valid=0, done=0, out_c=0.
- start accepted at edge t: in_ready=1 and busy=1 from cycle t+1.
- Last beat accepted at edge t: out_valid rises in cycle t+ROWS+COLS-1 (31 cycles for 16×16).
- k_len==0: out_valid rises ROWS+COLS-1 cycles after start is accepted, with all results 0.
- Back-to-back: earliest next start is in the cycle after the output handshake.
- out_c is registered. No combinational path from in_* or out_ready to out_c.

## Configuration
- SYSTOLIC_SAT_EN defined: each result is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- SYSTOLIC_SAT_EN undefined: each result is truncated to acc[OUT_W-1:0] (two's-complement wrap).

## Structure
- Package systolic_pkg holds:
  - the state enum typedef (S_IDLE, S_LOAD, S_DRAIN, S_OUT);
  - localparam width helpers for the beat and drain counters;
  - the saturate/truncate function.
- Sub-module systolic_pe: one PE holding the operand forward registers and the accumulator, with a synchronous clear input. It is instantiated ROWS×COLS times via generate.

## Test plan
- Identity: A=I16, B(k,j)=k+j, k_len=16, contiguous beats → out_c(i,j)=i+j; out_valid exactly 31 cycles after the last beat edge; done pulses once.
- Input bubbles: same job with in_valid toggling every other cycle → identical out_c.
- Overflow: A=B=all 127, k_len=16 (acc=258064) → out_c all 127 with SYSTOLIC_SAT_EN; all 16 without it.
- Signedness: k_len=1, A=all -3, B=all 5 → out_c all -15 (0xF1) in both builds.
- Output backpressure: out_ready low for 10 cycles → out_valid and out_c stable; a start pulse during that window is ignored; done pulses only on the handshake.
- Reset mid-S_LOAD after 5 beats → next cycle all outputs at reset values and busy=0; a fresh identity job then produces the correct result.
